test_port_writer: RTL and testbench

//  Drives the memory-mapped test port (word addr 30'h3FF) so the bench checker scores a run.

---
 rtl/test_port_writer_if.sv | 37 +++
 rtl/test_port_writer.sv | 242 ++++++++++++++++++++++++
 tb/tb_test_port_writer.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/test_port_writer_if.sv
// ---------------------------------------------------------------------------
// test_port_writer_if
//   Groups the payload stream (producer -> writer) and the data-memory write
//   bus (writer -> memory) used by test_port_writer.
//
//   Signals:
//     in_valid   producer -> writer   payload word valid
//     in_data    producer -> writer   payload word, readable (big-endian) order
//     in_ready   writer   -> producer writer can accept a word this cycle
//     mem_stall  memory   -> writer   write bus stalled
//     addr       writer   -> memory   word address (30'h3FF while wen=1)
//     data       writer   -> memory   byte-swapped write data
//     wen        writer   -> memory   write enable
//
//   Modports:
//     master  the writer side (drives the bus and in_ready)
//     slave   the environment side (producer and memory)
// ---------------------------------------------------------------------------
interface test_port_writer_if;
    logic        in_valid;
    logic [31:0] in_data;
    logic        in_ready;
    logic        mem_stall;
    logic [29:0] addr;
    logic [31:0] data;
    logic        wen;

    modport master (
        input  in_valid, in_data, mem_stall,
        output in_ready, addr, data, wen
    );

    modport slave (
        output in_valid, in_data, mem_stall,
        input  in_ready, addr, data, wen
    );
endinterface

// File: rtl/test_port_writer.sv
// ---------------------------------------------------------------------------
// test_port_writer
//   Writes a scored report to the memory-mapped test port (word address
//   30'h3FF): the begin symbol, NUM_WORDS payload words taken from an
//   internal FIFO, then the end symbol. Each word is a single wen episode,
//   separated from the next by at least one wen-low cycle, and the D-cache
//   stall holds the current write until it completes.
//
//   Parameters:
//     NUM_WORDS   payload words between begin and end symbols (<= 1023)
//     FIFO_DEPTH  payload FIFO entries (power of 2, >= 2)
//     TIMEOUT     empty-FIFO wait limit in GAP cycles (TPW_TIMEOUT_EN only)
//
//   Ports:
//     clk      in   clock, rising edge
//     rst      in   asynchronous active-low reset
//     start    in   one-cycle pulse, starts a report (honoured only in IDLE)
//     bus      if   master modport: payload stream in, memory write bus out
//     busy     out  1 while a report is in progress (not IDLE, not DONE)
//     done     out  1 once the end symbol has been written (sticky)
//     timeout  out  sticky flag: report ended early on a starved FIFO
//
//   Build option:
//     TPW_TIMEOUT_EN  when defined, a GAP state starved for TIMEOUT cycles
//                     ends the report early with the end symbol and sets
//                     timeout. When undefined GAP waits forever and timeout
//                     is tied low.
// ---------------------------------------------------------------------------
module test_port_writer #(
    parameter int NUM_WORDS  = 120,
    parameter int FIFO_DEPTH = 8,
    parameter int TIMEOUT    = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    test_port_writer_if.master bus,
    output logic               busy,
    output logic               done,
    output logic               timeout
);

    localparam int          AW        = $clog2(FIFO_DEPTH);
    localparam logic [31:0] BEGIN_SYM = 32'h00000168;
    localparam logic [31:0] END_SYM   = 32'hFFFFFD5D;
    localparam logic [29:0] PORT_ADDR = 30'h3FF;
    localparam logic [9:0]  LAST_CNT  = 10'(NUM_WORDS);
    localparam logic [AW:0] FULL_CNT  = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_BEG_WR,
        S_GAP,
        S_DAT_WR,
        S_END_WR,
        S_DONE
    } state_t;

    // The checker reads the port little-endian, so words go out byte-reversed.
    function automatic logic [31:0] byte_swap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    state_t        state, state_nxt;
    logic [9:0]    word_cnt;
    logic          cnt_inc;

    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic          fifo_empty, fifo_full;
    logic          push, pop;

    logic          wen_nxt;
    logic [29:0]   addr_nxt;
    logic [31:0]   data_nxt;
    logic          busy_nxt, done_nxt;

    // ---------------------------------------------------------------------
    // Payload FIFO
    // ---------------------------------------------------------------------
    assign fifo_empty = (fifo_cnt == '0);
    assign fifo_full  = (fifo_cnt == FULL_CNT);
    // A pop in the same cycle frees the slot, so a full FIFO can still take
    // a word while the head is being retired.
    assign bus.in_ready = !fifo_full || pop;
    assign push         = bus.in_valid && bus.in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_ONE;
                2'b01:   fifo_cnt <= fifo_cnt - CNT_ONE;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // Storage carries data only; validity is tracked by fifo_cnt.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr] <= bus.in_data;
    end

`ifdef TPW_TIMEOUT_EN
    localparam logic [15:0] WAIT_LIMIT = 16'(TIMEOUT - 1);
    logic [15:0] wait_cnt, wait_nxt;
    logic        timeout_set;
`endif

    // ---------------------------------------------------------------------
    // Next-state logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        cnt_inc   = 1'b0;
`ifdef TPW_TIMEOUT_EN
        wait_nxt    = wait_cnt;
        timeout_set = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_BEG_WR;
            end
            S_BEG_WR: begin
                if (!bus.mem_stall) state_nxt = S_GAP;
            end
            S_GAP: begin
                if (word_cnt == LAST_CNT) begin
                    state_nxt = S_END_WR;
                end else if (!fifo_empty) begin
                    state_nxt = S_DAT_WR;
                end
`ifdef TPW_TIMEOUT_EN
                // Starved: the limit is hit on the TIMEOUT-th waiting cycle.
                else if (wait_cnt == WAIT_LIMIT) begin
                    state_nxt   = S_END_WR;
                    timeout_set = 1'b1;
                end else begin
                    wait_nxt = wait_cnt + 16'd1;
                end
`endif
            end
            S_DAT_WR: begin
                if (!bus.mem_stall) begin
                    pop       = 1'b1;
                    cnt_inc   = 1'b1;
                    state_nxt = S_GAP;
                end
            end
            S_END_WR: begin
                if (!bus.mem_stall) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_DONE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
`ifdef TPW_TIMEOUT_EN
        if (state_nxt != S_GAP) wait_nxt = '0;
`endif
    end

    // Outputs are decoded from the next state and registered, so the bus
    // shows the word one cycle after the decision. During a stall the state
    // and read pointer do not move, which keeps addr/data stable.
    always_comb begin
        wen_nxt  = 1'b0;
        data_nxt = '0;
        case (state_nxt)
            S_BEG_WR: begin
                wen_nxt  = 1'b1;
                data_nxt = byte_swap(BEGIN_SYM);
            end
            S_DAT_WR: begin
                wen_nxt  = 1'b1;
                data_nxt = byte_swap(fifo_mem[rd_ptr]);
            end
            S_END_WR: begin
                wen_nxt  = 1'b1;
                data_nxt = byte_swap(END_SYM);
            end
            default: begin
                wen_nxt  = 1'b0;
                data_nxt = '0;
            end
        endcase
        addr_nxt = wen_nxt ? PORT_ADDR : '0;
        busy_nxt = (state_nxt != S_IDLE) && (state_nxt != S_DONE);
        done_nxt = (state_nxt == S_DONE);
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            word_cnt <= '0;
            bus.wen  <= 1'b0;
            bus.addr <= '0;
            bus.data <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            state    <= state_nxt;
            if (cnt_inc) word_cnt <= word_cnt + 10'd1;
            bus.wen  <= wen_nxt;
            bus.addr <= addr_nxt;
            bus.data <= data_nxt;
            busy     <= busy_nxt;
            done     <= done_nxt;
        end
    end

`ifdef TPW_TIMEOUT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            wait_cnt <= wait_nxt;
            if (timeout_set) timeout <= 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
    logic [15:0] unused_timeout;
    assign unused_timeout = 16'(TIMEOUT);
`endif

endmodule

// File: tb/tb_test_port_writer.sv
// ---------------------------------------------------------------------------
// tb_test_port_writer
//   Directed bench for test_port_writer. A producer process feeds payload
//   words 0,1,2,... up to a limit; a monitor records every completed write.
//   Expected words are derived independently: word k is sent byte-reversed,
//   which for k < 256 is simply k in the top byte.
// ---------------------------------------------------------------------------
module tb_test_port_writer;

    localparam int          NW      = 120;
    localparam logic [31:0] BEG_EXP = 32'h68010000;
    localparam logic [31:0] END_EXP = 32'h5DFDFFFF;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic start = 1'b0;
    logic busy, done, timeout;

    test_port_writer_if ifc ();

    test_port_writer #(
        .NUM_WORDS (NW),
        .FIFO_DEPTH(8),
        .TIMEOUT   (16)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .bus    (ifc),
        .busy   (busy),
        .done   (done),
        .timeout(timeout)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int t = 0;
    int wi = 0;
    int prod_lim = 0;
    bit prod_en = 1'b0;
    logic [31:0] wr_q [$];
    int bad_addr = 0;
    int bad_idle = 0;
    int b2b = 0;
    bit prev_cmp = 1'b0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, act, exp);
    endtask

    // Inputs change 2 ns after the rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #2;
        t++;
    endtask

    // Producer: offers word wi while below prod_lim, advances on acceptance.
    initial begin
        logic acc;
        ifc.in_valid = 1'b0;
        ifc.in_data  = '0;
        forever begin
            @(negedge clk);
            acc = rst && ifc.in_valid && ifc.in_ready;
            @(posedge clk);
            #1;
            if (acc) wi++;
            ifc.in_valid = prod_en && (wi < prod_lim);
            ifc.in_data  = 32'(wi);
        end
    end

    // Monitor: records completed writes and flags bus protocol slips.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev_cmp = 1'b0;
            end else begin
                if (ifc.wen) begin
                    if (ifc.addr !== 30'h3FF) bad_addr++;
                    if (prev_cmp) b2b++;
                end else if (ifc.addr !== '0 || ifc.data !== '0) begin
                    bad_idle++;
                end
                prev_cmp = ifc.wen && !ifc.mem_stall;
                if (prev_cmp) wr_q.push_back(ifc.data);
            end
        end
    end

    task automatic do_reset();
        rst = 1'b0;
        start = 1'b0;
        ifc.mem_stall = 1'b0;
        prod_en = 1'b0;
        prod_lim = 0;
        wi = 0;
        repeat (3) step();
        rst = 1'b1;
        wr_q.delete();
        bad_addr = 0;
        bad_idle = 0;
        b2b = 0;
        step();
    endtask

    // Preloads the FIFO, then pulses start; returns at t=1 (first wen cycle).
    task automatic begin_run(input int lim);
        prod_lim = lim;
        prod_en = 1'b1;
        repeat (10) step();
        start = 1'b1;
        t = 0;
        step();
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        while (!done && t < limit) step();
    endtask

    task automatic check_seq(input string tag, input int nwords);
        logic [31:0] exp_q [$];
        int err;
        int n;
        err = 0;
        exp_q.push_back(BEG_EXP);
        for (int k = 0; k < nwords; k++) exp_q.push_back({8'(k), 24'h0});
        exp_q.push_back(END_EXP);
        chk({tag, "_len"}, 32'(wr_q.size()), 32'(exp_q.size()));
        n = (wr_q.size() < exp_q.size()) ? wr_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            if (wr_q[i] !== exp_q[i]) err++;
        end
        chk({tag, "_seq_err"}, 32'(err), 32'd0);
        chk({tag, "_addr_err"}, 32'(bad_addr), 32'd0);
        chk({tag, "_idle_err"}, 32'(bad_idle), 32'd0);
        chk({tag, "_no_gap"}, 32'(b2b), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int wen_hi;
        int n;
        ifc.mem_stall = 1'b0;

        // Reset values and unstalled full report with exact timing
        do_reset();
        chk("rst_wen", {31'b0, ifc.wen}, 32'd0);
        chk("rst_addr", {2'b0, ifc.addr}, 32'd0);
        chk("rst_data", ifc.data, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_timeout", {31'b0, timeout}, 32'd0);
        chk("rst_in_ready", {31'b0, ifc.in_ready}, 32'd1);

        begin_run(NW);
        chk("A_beg_wen", {31'b0, ifc.wen}, 32'd1);
        chk("A_beg_data", ifc.data, BEG_EXP);
        chk("A_beg_addr", {2'b0, ifc.addr}, 32'h3FF);
        chk("A_busy", {31'b0, busy}, 32'd1);
        step();
        chk("A_gap_wen", {31'b0, ifc.wen}, 32'd0);
        step();
        chk("A_w0_wen", {31'b0, ifc.wen}, 32'd1);
        wait_done(400);
        chk("A_done_cycle", 32'(t), 32'd244);
        chk("A_busy_end", {31'b0, busy}, 32'd0);
        chk("A_timeout_end", {31'b0, timeout}, 32'd0);
        check_seq("A", NW);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        chk("A_start_in_done_wen", {31'b0, ifc.wen}, 32'd0);
        chk("A_done_sticky", {31'b0, done}, 32'd1);

`ifndef TPW_TIMEOUT_EN
        // FIFO overflow in IDLE, stall on word 5, producer starvation after word 10
        do_reset();
        prod_lim = 9;
        prod_en = 1'b1;
        repeat (12) step();
        chk("B_ovf_accepted", 32'(wi), 32'd8);
        chk("B_ovf_ready", {31'b0, ifc.in_ready}, 32'd0);
        chk("B_ovf_held", {31'b0, ifc.in_valid}, 32'd1);
        start = 1'b1;
        t = 0;
        step();
        start = 1'b0;
        step();
        step();
        chk("B_full_pop_ready", {31'b0, ifc.in_ready}, 32'd1);
        step();
        chk("B_full_gap_ready", {31'b0, ifc.in_ready}, 32'd0);
        prod_lim = 11;
        while (t < 13) step();
        chk("B_w5_wen", {31'b0, ifc.wen}, 32'd1);
        chk("B_w5_data", ifc.data, 32'h05000000);
        ifc.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("B_stall_wen", {31'b0, ifc.wen}, 32'd1);
            chk("B_stall_data", ifc.data, 32'h05000000);
        end
        ifc.mem_stall = 1'b0;
        step();
        chk("B_after_stall_wen", {31'b0, ifc.wen}, 32'd0);
        while (t < 26) step();
        chk("B_w10_data", ifc.data, 32'h0A000000);
        step();
        wen_hi = 0;
        repeat (50) begin
            if (ifc.wen) wen_hi++;
            step();
        end
        chk("B_starve_wen", 32'(wen_hi), 32'd0);
        chk("B_starve_busy", {31'b0, busy}, 32'd1);
        chk("B_starve_timeout", {31'b0, timeout}, 32'd0);
        prod_lim = NW;
        n = 0;
        while (!ifc.wen && n < 10) begin
            step();
            n++;
        end
        chk("B_resume_data", ifc.data, 32'h0B000000);
        wait_done(800);
        chk("B_done", {31'b0, done}, 32'd1);
        check_seq("B", NW);
`endif

        // Asynchronous reset mid-payload, then a fresh report
        do_reset();
        begin_run(NW);
        while (t < 63) step();
        chk("C_w30_wen", {31'b0, ifc.wen}, 32'd1);
        chk("C_w30_data", ifc.data, 32'h1E000000);
        rst = 1'b0;
        prod_en = 1'b0;
        #1;
        chk("C_rst_wen", {31'b0, ifc.wen}, 32'd0);
        chk("C_rst_busy", {31'b0, busy}, 32'd0);
        chk("C_rst_data", ifc.data, 32'd0);
        chk("C_rst_in_ready", {31'b0, ifc.in_ready}, 32'd1);
        wi = 0;
        step();
        step();
        rst = 1'b1;
        wr_q.delete();
        bad_addr = 0;
        bad_idle = 0;
        b2b = 0;
        step();
        begin_run(NW);
        chk("C_rebegin_wen", {31'b0, ifc.wen}, 32'd1);
        chk("C_rebegin_data", ifc.data, BEG_EXP);
        while (t < 5) step();
        chk("C_re_w1_data", ifc.data, 32'h01000000);
        wait_done(400);
        chk("C_done", {31'b0, done}, 32'd1);
        check_seq("C", NW);

`ifdef TPW_TIMEOUT_EN
        // Producer starves after word 3; the report must end early
        do_reset();
        begin_run(4);
        wait_done(200);
        chk("D_done", {31'b0, done}, 32'd1);
        chk("D_timeout", {31'b0, timeout}, 32'd1);
        check_seq("D", 4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
